// File: rtl/ahb_arbiter_pkg.sv
// Shared types and width helpers for the AHB round-robin arbiter.
//   arb_state_e : arbiter FSM state encoding (IDLE / GRANT / HANDOVER)
//   idx_width   : width of a master index, clog2 with a floor of 1
//   cnt_width   : width of the tenure counter, wide enough to hold MAX_HOLD
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        HANDOVER = 2'd2
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_width(input int max_hold);
        return $clog2(max_hold + 1);
    endfunction

    localparam int DEFAULT_MAX_HOLD = 16;
    localparam int DEFAULT_CNT_W    = cnt_width(DEFAULT_MAX_HOLD);

endpackage

// File: rtl/ahb_arbiter_if.sv
// Request/grant bundle between the bus masters and the arbiter.
//   hreq          : per-master level request
//   hready        : current transfer phase complete (gates preemption)
//   hgrant        : registered one-hot grant
//   hmaster       : current / most recent owner index (mux select)
//   hmaster_valid : high exactly when hgrant is nonzero
// Modports: master = requester side, slave = arbiter side.
interface ahb_arbiter_if
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4
) ();

    localparam int IW = idx_width(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] hreq;
    logic                   hready;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [IW-1:0]          hmaster;
    logic                   hmaster_valid;

    modport master (
        output hreq, hready,
        input  hgrant, hmaster, hmaster_valid
    );

    modport slave (
        input  hreq, hready,
        output hgrant, hmaster, hmaster_valid
    );

endinterface

// File: rtl/ahb_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector
//   last    : index of the previous winner (lowest priority this round)
//   winner  : first requesting index searching upward from last+1, wrapping
//   any_req : at least one request is present (winner is only meaningful then)
module rr_pick
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int IW          = idx_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IW-1:0]          last,
    output logic [IW-1:0]          winner,
    output logic                   any_req
);

    logic [IW-1:0] idx;
    logic          found;

    assign any_req = |req;

    // NOTE: combinational scratch variables use blocking '=' so each loop
    // iteration sees the previous one's result; flops elsewhere use '<='.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        // Offset 1..N from last; offset N lands back on last itself so the
        // previous owner is considered, but only after everyone else.
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = IW'((int'(last) + i) % NUM_MASTERS);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter with bounded tenure.
//   hclk    : clock, rising edge
//   hresetn : asynchronous active-low reset
//   bus     : ahb_arbiter_if.slave (hreq/hready in, hgrant/hmaster/
//             hmaster_valid out, all outputs straight from flops)
// An owner keeps the bus while it requests; once it has spent MAX_HOLD
// cycles in GRANT and another master is waiting, it is revoked on the next
// cycle with hready high. Every change of owner passes through one dead
// HANDOVER cycle.
module ahb_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_HOLD    = 16
) (
    input  logic          hclk,
    input  logic          hresetn,
    ahb_arbiter_if.slave  bus
);

    localparam int IW = idx_width(NUM_MASTERS);
    localparam int CW = cnt_width(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]          master_q, master_d;
    logic [IW-1:0]          last_q, last_d;
    logic                   valid_q, valid_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;

    logic [IW-1:0]          winner;
    logic                   any_req;
    logic [NUM_MASTERS-1:0] win_onehot;
    logic                   owner_req;
    logic                   others_req;
    logic                   preempt;

    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IW          (IW)
    ) u_pick (
        .req     (bus.hreq),
        .last    (last_q),
        .winner  (winner),
        .any_req (any_req)
    );

    assign win_onehot = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << winner;
    assign owner_req  = |(bus.hreq & grant_q);
    assign others_req = |(bus.hreq & ~grant_q);

    // cnt_inc is the count including the current GRANT cycle, so the owner
    // gets exactly MAX_HOLD GRANT cycles before a preemption can land.
    assign cnt_inc = (cnt_q == HOLD_MAX) ? cnt_q : cnt_q + CW'(1);
    assign preempt = (cnt_inc == HOLD_MAX) && others_req && bus.hready;

    // NOTE: every output of this block is assigned a default first, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        master_d = master_q;
        last_d   = last_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            IDLE, HANDOVER: begin
                if (any_req) begin
                    state_d  = GRANT;
                    grant_d  = win_onehot;
                    master_d = winner;
                    last_d   = winner;
                    valid_d  = 1'b1;
                    cnt_d    = '0;
                end else begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    valid_d  = 1'b0;
                end
            end
            GRANT: begin
                cnt_d = cnt_inc;
                if (!owner_req || preempt) begin
                    // hmaster keeps the old index through the dead cycle.
                    state_d = HANDOVER;
                    grant_d = '0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            master_q <= '0;
            last_q   <= IW'(NUM_MASTERS - 1);
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            master_q <= master_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.hgrant        = grant_q;
    assign bus.hmaster       = master_q;
    assign bus.hmaster_valid = valid_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter (4 masters, MAX_HOLD = 4).
module tb_ahb_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;

    typedef struct packed {
        logic [3:0] req;
        logic       rdy;
        logic [3:0] grant;
        logic [1:0] master;
        logic       valid;
    } vec_t;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] master;
        logic       valid;
    } exp_t;

    logic hclk;
    logic hresetn;

    ahb_arbiter_if #(.NUM_MASTERS(N)) bus ();

    ahb_arbiter #(
        .NUM_MASTERS (N),
        .MAX_HOLD    (MH)
    ) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: drive inputs, queue the expectation, compare it
    // just after the following rising edge, then return to the negedge.
    task automatic step(input logic [3:0] req, input logic rdy, input logic [3:0] g,
                        input logic [1:0] m, input logic v, input string name);
        exp_t e;
        bus.hreq   = req;
        bus.hready = rdy;
        e.grant  = g;
        e.master = m;
        e.valid  = v;
        sb.push_back(e);
        @(posedge hclk);
        #1;
        if (sb.size() == 0) begin
            check({name, " scoreboard"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({name, " hgrant"},  32'(bus.hgrant),        32'(e.grant));
            check({name, " hmaster"}, 32'(bus.hmaster),       32'(e.master));
            check({name, " valid"},   32'(bus.hmaster_valid), 32'(e.valid));
        end
        @(negedge hclk);
    endtask

    task automatic check_cleared(input string name);
        check({name, " hgrant"},  32'(bus.hgrant),        32'd0);
        check({name, " hmaster"}, 32'(bus.hmaster),       32'd0);
        check({name, " valid"},   32'(bus.hmaster_valid), 32'd0);
    endtask

    task automatic do_reset(input string name);
        @(negedge hclk);
        hresetn  = 1'b0;
        bus.hreq = '0;
        #1;
        check_cleared(name);
        @(negedge hclk);
        hresetn = 1'b1;
    endtask

    // Expected outputs for edge j (1-based) of a continuous 4'b1111 run from
    // reset: each tenure is MH GRANT cycles followed by one dead cycle.
    task automatic rot_step(input int j, input string name);
        int owner;
        int phase;
        owner = ((j - 1) / (MH + 1)) % N;
        phase = (j - 1) % (MH + 1);
        if (phase < MH)
            step(4'b1111, 1'b1, 4'(1 << owner), 2'(owner), 1'b1, name);
        else
            step(4'b1111, 1'b1, 4'b0000, 2'(owner), 1'b0, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            req      rdy   grant    mst   valid
        vecs[0]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[1]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[2]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[3]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[4]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
        vecs[5]  = '{4'b0110, 1'b1, 4'b0010, 2'd1, 1'b1};
        vecs[6]  = '{4'b0110, 1'b1, 4'b0010, 2'd1, 1'b1};
        vecs[7]  = '{4'b0100, 1'b1, 4'b0000, 2'd1, 1'b0};
        vecs[8]  = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1};
        vecs[9]  = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0};
        vecs[10] = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0};

        hresetn    = 1'b0;
        bus.hreq   = '0;
        bus.hready = 1'b1;
        repeat (2) @(negedge hclk);
        check_cleared("reset");
        hresetn = 1'b1;
        @(negedge hclk);

        // Idle, first grant, release with one dead cycle, return to idle.
        for (int i = 0; i < 11; i++)
            step(vecs[i].req, vecs[i].rdy, vecs[i].grant, vecs[i].master,
                 vecs[i].valid, $sformatf("vec%0d", i));

        // Full rotation 0->1->2->3->0 under continuous contention.
        do_reset("rot reset");
        for (int j = 1; j <= 4 * (MH + 1) + 2; j++)
            rot_step(j, $sformatf("rot%0d", j));

        // Preemption held off by hready, then revoked on the first ready cycle.
        do_reset("pre reset");
        for (int j = 0; j < 5; j++)
            step(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, $sformatf("pre_own%0d", j));
        for (int j = 0; j < 3; j++)
            step(4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, $sformatf("pre_wait%0d", j));
        step(4'b0101, 1'b1, 4'b0000, 2'd2, 1'b0, "pre_revoke");
        step(4'b0101, 1'b1, 4'b0001, 2'd0, 1'b1, "pre_newown");

        // Sole requester never loses the bus after saturation.
        do_reset("sole reset");
        for (int j = 0; j < 40; j++)
            step(4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, $sformatf("sole%0d", j));

        // Reset while master 1 owns the bus with everyone requesting.
        do_reset("mid reset");
        for (int j = 1; j <= MH + 2; j++)
            rot_step(j, $sformatf("mid%0d", j));
        hresetn = 1'b0;
        #1;
        check_cleared("mid async clear");
        @(negedge hclk);
        hresetn = 1'b1;
        step(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, "mid after release");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin bus arbiter that shares the single AHB address/data path between up to `NUM_MASTERS` bus masters. Each master raises `hreq` and waits for `hgrant` before driving the bus. The arbiter issues a registered one-hot grant and a master index (`hmaster`) that steers the address/write-data mux. It enforces a bounded tenure so that no master can starve the others.

## Interface
Parameters:
- `NUM_MASTERS`, 4: number of requesters; legal range 2..16.
- `MAX_HOLD`, 16: maximum number of cycles in GRANT before the owner is preempted when another master is waiting; must be ≥ 2.

Ports:
- `hclk` in 1: single clock; all logic is on the rising edge.
- `hresetn` in 1: asynchronous, active-low reset.
- `hreq` in NUM_MASTERS: per-master bus request, level-sensitive.
- `hready` in 1: high when the current owner's transfer phase is complete; preemption happens only on a cycle where this is high.
- `hgrant` out NUM_MASTERS: one-hot grant, registered; all zero when the bus is not owned.
- `hmaster` out clog2(NUM_MASTERS): index of the current or most recent owner; drives the mux select.
- `hmaster_valid` out 1: high exactly when `hgrant` is nonzero.

## Operation
- Reset values: state IDLE, `hgrant`=0, `hmaster`=0, `hmaster_valid`=0, hold counter 0, round-robin pointer `last`=NUM_MASTERS-1, so master 0 has first priority.
- Winner selection: the search starts at `(last+1) mod NUM_MASTERS`, ascending with wrap-around. The first index with `hreq` set wins.
- IDLE:
  - If `hreq` is 0, stay in IDLE.
  - Otherwise latch the winner into `hgrant`/`hmaster`, set `last` to the winner, clear the counter, and go to GRANT.
- GRANT:
  - Each cycle the counter increments and saturates at MAX_HOLD.
  - If the owner's `hreq`=0, go to HANDOVER.
  - If counter==MAX_HOLD, any other `hreq` bit is set, and `hready`=1, go to HANDOVER (preemption).
  - Otherwise stay; the grant is unchanged.
- HANDOVER: lasts exactly one cycle. `hgrant`=0, `hmaster_valid`=0, and `hmaster` keeps the old index.
  - If any `hreq` is set, arbitrate as in IDLE and go to GRANT.
  - Otherwise go to IDLE.
- Handling of the preempted master: it may keep `hreq` high. It re-enters arbitration as the lowest-priority requester because `last` points to it.
- When the owner is the sole requester, it holds indefinitely. Saturation of the counter has no effect without a competing request.
- Simultaneous events:
  - An owner dropping `hreq` on the same cycle preemption triggers is a single transition to HANDOVER.
  - A new request arriving in the HANDOVER cycle is considered in that same arbitration.
- Reset mid-tenure: all outputs clear immediately (asynchronous). After release, master 0 has priority again.
- Masking: `hreq` bits at or above NUM_MASTERS do not exist, and no out-of-range index is ever produced.

## Timing
- Grant latency from IDLE: `hreq` sampled high at edge k gives `hgrant` high after edge k (1 cycle).
- Release to next grant: the owner's `hreq` low at edge k gives HANDOVER after edge k and the new grant after edge k+1. This is 2 cycles, including one mandatory dead cycle.
- Preemption: with a competing request, the earliest revoke is the edge at which the counter has reached MAX_HOLD and `hready`=1. The new owner is granted one edge later.
- All outputs come directly from flops; there is no combinational path from `hreq` to `hgrant`.

## Structure
- Package `ahb_arb_pkg`:
  - state enum {IDLE, GRANT, HANDOVER}, 2 bits;
  - function computing the index width (clog2, minimum 1);
  - counter width constant, derived from MAX_HOLD.
- Sub-module `rr_pick`: purely combinational. Inputs are the request vector and `last`; outputs are the winner index and an any-request flag. It is instantiated once in the top level, and the FSM, counter and `last` register live in the top level.

## Test plan
- Reset, then `hreq`=4'b0000 for 5 cycles: `hgrant`=0, `hmaster`=0 and `hmaster_valid`=0 throughout.
- `hreq`=4'b0110 from IDLE:
  - `hgrant`=4'b0010 one cycle later;
  - master 1 drops `hreq`: one dead cycle, then `hgrant`=4'b0100.
- All four requesting continuously with MAX_HOLD=4 and `hready`=1: grants rotate 0→1→2→3→0. Each tenure is 4 cycles in GRANT plus 1 HANDOVER, with no master skipped.
- Preemption gating (MAX_HOLD=4):
  - master 2 owns the bus and master 0 requests, with `hready`=0 for 3 cycles after saturation: the grant holds;
  - on the first cycle with `hready`=1 the grant is revoked, and `hgrant`=4'b0001 two edges later.
- Sole requester master 3 holds for 40 cycles: `hgrant`=4'b1000 for all 40 cycles and the arbiter never enters HANDOVER.
- `hresetn` is pulsed low mid-GRANT with `hreq`=4'b1111 held:
  - outputs clear asynchronously;
  - after release, `hgrant`=4'b0001 one cycle later.
